// File: rtl/core_monitor_if.sv
// Bundle between a retiring core, the core_monitor, and a trace sink.
// master = core/trace-sink side, slave = monitor side.
interface core_monitor_if;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [31:0] inst_in;
  logic [31:0] v0_in;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [31:0] syscall_pc;
  logic [31:0] syscall_v0;
  logic [31:0] inst_count;
  logic        trace_valid;
  logic        trace_ready;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic        trace_overflow;

  modport master (
    output valid_in, pc_in, inst_in, v0_in, trace_ready,
    input  halted, halt_cause, syscall_pc, syscall_v0, inst_count,
           trace_valid, trace_pc, trace_inst, trace_overflow
  );

  modport slave (
    input  valid_in, pc_in, inst_in, v0_in, trace_ready,
    output halted, halt_cause, syscall_pc, syscall_v0, inst_count,
           trace_valid, trace_pc, trace_inst, trace_overflow
  );
endinterface

// File: rtl/core_monitor.sv
// Watches core retirements: halts on syscall or cycle timeout, counts instructions.
// Define CORE_MONITOR_TRACE_EN to build the retirement trace FIFO; otherwise the trace port reads 0.
module core_monitor #(
  parameter int TIMEOUT_CYCLES = 500,
  parameter int TRACE_DEPTH    = 8
) (
  input logic           clk,
  input logic           rst,
  core_monitor_if.slave mon
);
  localparam logic [31:0] SYSCALL = 32'h0000000C;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {RUN = 2'd0, HALT_SYS = 2'd1, HALT_TO = 2'd2} state_t;

  state_t      state;
  logic [31:0] cycle_cnt, inst_count, syscall_pc, syscall_v0;
  logic        halted;
  logic [1:0]  halt_cause;
  logic        retire, is_sys;

  assign retire = (state == RUN) && mon.valid_in;
  assign is_sys = retire && (mon.inst_in == SYSCALL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      cycle_cnt  <= '0;
      inst_count <= '0;
      syscall_pc <= '0;
      syscall_v0 <= '0;
      halted     <= 1'b0;
      halt_cause <= 2'b00;
    end else if (state == RUN) begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (retire && inst_count != '1) inst_count <= inst_count + 32'd1;
      // syscall takes priority over a timeout landing on the same edge
      if (is_sys) begin
        state      <= HALT_SYS;
        halted     <= 1'b1;
        halt_cause <= 2'b01;
        syscall_pc <= mon.pc_in;
        syscall_v0 <= mon.v0_in;
      end else if (cycle_cnt == TO_LAST) begin
        state      <= HALT_TO;
        halted     <= 1'b1;
        halt_cause <= 2'b10;
      end
    end
  end

  assign mon.halted     = halted;
  assign mon.halt_cause = halt_cause;
  assign mon.syscall_pc = syscall_pc;
  assign mon.syscall_v0 = syscall_v0;
  assign mon.inst_count = inst_count;

`ifdef CORE_MONITOR_TRACE_EN
  localparam int          AW       = $clog2(TRACE_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(TRACE_DEPTH);

  logic [63:0]   mem [TRACE_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [AW:0]   count;
  logic [63:0]   wdata, head, head_nxt;
  logic          empty, full, push, pop, overflow;

  assign wdata   = {mon.pc_in, mon.inst_in};
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop     = !empty && mon.trace_ready;
  assign push    = retire && (!full || pop);
  assign rd_next = rd_ptr + AW'(1);

  // Head register holds what will be at the front after this edge.
  always_comb begin
    head_nxt = head;
    if (pop) begin
      if (count == (AW+1)'(1)) head_nxt = push ? wdata : '0;
      else                     head_nxt = mem[rd_next];
    end else if (empty && push) begin
      head_nxt = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      head     <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
      head <= head_nxt;
      if (retire && full && !pop) overflow <= 1'b1;
    end
  end

  assign mon.trace_valid    = !empty;
  assign mon.trace_pc       = head[63:32];
  assign mon.trace_inst     = head[31:0];
  assign mon.trace_overflow = overflow;
`else
  localparam int unused_depth = TRACE_DEPTH;
  logic unused_trace_ready;
  assign unused_trace_ready  = mon.trace_ready;
  assign mon.trace_valid     = 1'b0;
  assign mon.trace_pc        = '0;
  assign mon.trace_inst      = '0;
  assign mon.trace_overflow  = 1'b0;
`endif
endmodule

// File: doc/core_monitor.md
CORE_MONITOR -- requirements
Module: core_monitor

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 500, SHALL set the cycle budget after reset release before a timeout halt.
REQ-002 Parameter TRACE_DEPTH, default 8, power of two >= 2, SHALL set the trace FIFO entry count.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 valid_in  input  1  SHALL mean the core retired the instruction on pc_in/inst_in this cycle.
REQ-006 pc_in  input  32  SHALL carry the core PC.
REQ-007 inst_in  input  32  SHALL carry the core current instruction.
REQ-008 v0_in  input  32  SHALL carry the core register $v0.
REQ-009 halted  output  1  SHALL signal that monitoring has stopped.
REQ-010 halt_cause  output  2  SHALL encode 00 none, 01 syscall, 10 timeout.
REQ-011 syscall_pc, syscall_v0  output  32 each  SHALL hold the PC and $v0 captured at syscall.
REQ-012 inst_count  output  32  SHALL count retired instructions.
REQ-013 trace_valid  output  1, trace_ready  input  1, trace_pc  output  32, trace_inst  output  32  SHALL form the trace drain port.
REQ-014 trace_overflow  output  1  SHALL be a sticky flag for dropped trace entries.

Function
REQ-015 FSM states RUN, HALT_SYS, HALT_TO; reset enters RUN; HALT states are terminal until reset.
REQ-016 Syscall: in RUN, valid_in=1 and inst_in==32'h0000000C SHALL capture pc_in/v0_in and move to HALT_SYS; halted=1 and halt_cause=01 visible the next cycle.
REQ-017 cycle_cnt (32 bit) SHALL increment every cycle in RUN; on reaching TIMEOUT_CYCLES-1 without a syscall, SHALL move to HALT_TO (halt_cause=10) on that edge.
REQ-018 Syscall and timeout on the same cycle: syscall SHALL win.
REQ-019 inst_count SHALL increment on each valid_in in RUN, including the syscall instruction, and saturate at 32'hFFFFFFFF; it SHALL freeze in HALT states.
REQ-020 Inputs with valid_in=0 SHALL be ignored except for the cycle count.
REQ-021 Trace push: each valid_in in RUN writes {pc_in, inst_in}, including the syscall instruction; no push in HALT states.
REQ-022 Trace pop: trace_valid && trace_ready removes the head entry; trace_valid = FIFO not empty; trace_pc/trace_inst show the head entry, registered, with no same-cycle bypass.
REQ-023 Push into an empty FIFO SHALL become visible on trace_valid one cycle later.
REQ-024 Full with a push and a pop in the same cycle: both SHALL occur and the count SHALL be unchanged.
REQ-025 Full with a push and no pop: the new entry SHALL be dropped and trace_overflow set to 1 until reset.
REQ-026 Draining SHALL continue in HALT states until empty.
REQ-027 Pointers SHALL wrap modulo TRACE_DEPTH; occupancy SHALL use a log2(TRACE_DEPTH)+1 bit count.

Reset
REQ-028 rst=1 SHALL asynchronously force RUN, cycle_cnt=0, inst_count=0, halted=0, halt_cause=00, syscall_pc=0, syscall_v0=0, FIFO empty, trace_valid=0, trace_pc=0, trace_inst=0, trace_overflow=0.
REQ-029 Reset mid-operation, including in HALT states or with a non-empty FIFO, SHALL discard all state; counting SHALL resume on the first edge after release.

Configuration
REQ-030 Macro CORE_MONITOR_TRACE_EN defined: the trace FIFO and REQ-021 to REQ-027 SHALL be implemented.
REQ-031 Macro not defined: no FIFO storage; trace_valid, trace_pc, trace_inst and trace_overflow SHALL be tied to 0; trace_ready is ignored; halt and count behaviour is unchanged.

Verification
REQ-032 Send 3 retirements, then inst 0000000C at pc 00400010 with v0=0000000A -> halted=1 and cause=01 the next cycle, syscall_pc=00400010, syscall_v0=0000000A, inst_count=4.
REQ-033 Set TIMEOUT_CYCLES=20 and never send a syscall -> halted=1 with cause=10 after 20 post-reset cycles; later valid_in leaves inst_count unchanged.
REQ-034 Set TIMEOUT_CYCLES=20 and send a syscall on cycle 19 -> cause=01.
REQ-035 Trace enabled, trace_ready=0, 10 retirements with TRACE_DEPTH=8 -> 8 entries held, trace_overflow=1; drain returns the first 8 PCs in order, then trace_valid=0.
REQ-036 FIFO full, push and pop in the same cycle -> occupancy stays 8, order preserved, no overflow.
REQ-037 Assert rst in HALT_SYS with 3 entries queued -> all outputs at reset values immediately, with no clock edge required.
